// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: sequences all traffic on the multiplexed-AD RTC bus.
// A refresh tick sweeps NREGS time/date registers through the read engine
// into the display register file. User writes are slotted in between sweep
// reads. A watchdog bounds every engine wait so a hung bus cannot stall us.
module rtc_bus_scheduler #(
  parameter int         NREGS     = 7,
  parameter logic [7:0] BASE_ADDR = 8'h21,
  parameter int         TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       rd_start,
  input  logic       rd_done,
  input  logic [7:0] rd_data,
  output logic       wr_start,
  input  logic       wr_done,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       reg_we,
  output logic [3:0] reg_idx,
  output logic [7:0] reg_data,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [3:0] LAST_IDX  = 4'(NREGS - 1);
  // The watchdog expires on the TIMEOUT-th wait cycle (count starts at 0).
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_STORE,
    S_WR_ISSUE,
    S_WR_WAIT
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_idx, w_idx_nxt;
  logic       r_tick_pend, w_tick_pend_nxt;
  logic       r_sweep, w_sweep_nxt;
  logic [7:0] r_wdog, w_wdog_nxt;
  logic [7:0] r_bus_addr, w_bus_addr_nxt;
  logic [7:0] r_bus_wdata, w_bus_wdata_nxt;
  logic [7:0] r_reg_data, w_reg_data_nxt;

  logic       w_rd_start, w_wr_start, w_reg_we, w_wr_ack, w_timeout;
  logic       w_expire;
  logic [3:0] w_idx_inc;

  assign w_expire  = (r_wdog == WDOG_LAST);
  assign w_idx_inc = r_idx + 4'd1;

  // State and datapath registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 4'd0;
      r_tick_pend <= 1'b0;
      r_sweep     <= 1'b0;
      r_wdog      <= 8'd0;
      r_bus_addr  <= 8'd0;
      r_bus_wdata <= 8'd0;
      r_reg_data  <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_tick_pend <= w_tick_pend_nxt;
      r_sweep     <= w_sweep_nxt;
      r_wdog      <= w_wdog_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      r_reg_data  <= w_reg_data_nxt;
    end
  end

  // Next-state, datapath updates and strobe decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_tick_pend_nxt = r_tick_pend | tick;  // ticks arriving while busy collapse here
    w_sweep_nxt     = r_sweep;
    w_wdog_nxt      = r_wdog;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_wdata_nxt = r_bus_wdata;
    w_reg_data_nxt  = r_reg_data;
    w_rd_start      = 1'b0;
    w_wr_start      = 1'b0;
    w_reg_we        = 1'b0;
    w_wr_ack        = 1'b0;
    w_timeout       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (wr_req) begin
          // A write beats a simultaneous tick, which stays pending.
          w_bus_addr_nxt  = wr_addr;
          w_bus_wdata_nxt = wr_data;
          w_state_nxt     = S_WR_ISSUE;
        end else if (tick || r_tick_pend) begin
          w_idx_nxt       = 4'd0;
          w_tick_pend_nxt = 1'b0;
          w_sweep_nxt     = 1'b1;
          w_bus_addr_nxt  = BASE_ADDR;
          w_state_nxt     = S_RD_ISSUE;
        end
      end

      S_RD_ISSUE: begin
        w_rd_start  = 1'b1;
        w_wdog_nxt  = 8'd0;
        w_state_nxt = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        w_wdog_nxt = r_wdog + 8'd1;
        if (rd_done) begin
          w_reg_data_nxt = rd_data;
          w_state_nxt    = S_RD_STORE;
        end else if (w_expire) begin
          // Abandon the sweep; the display keeps its previous contents.
          w_timeout   = 1'b1;
          w_idx_nxt   = 4'd0;
          w_sweep_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end

      S_RD_STORE: begin
        w_reg_we = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_idx_nxt   = 4'd0;
          w_sweep_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_idx_nxt = w_idx_inc;
          if (wr_req) begin
            w_bus_addr_nxt  = wr_addr;
            w_bus_wdata_nxt = wr_data;
            w_state_nxt     = S_WR_ISSUE;
          end else begin
            w_bus_addr_nxt = BASE_ADDR + {4'd0, w_idx_inc};
            w_state_nxt    = S_RD_ISSUE;
          end
        end
      end

      S_WR_ISSUE: begin
        w_wr_start  = 1'b1;
        w_wdog_nxt  = 8'd0;
        w_state_nxt = S_WR_WAIT;
      end

      S_WR_WAIT: begin
        w_wdog_nxt = r_wdog + 8'd1;
        if (wr_done || w_expire) begin
          // An expired write is still acked so the requester never hangs.
          w_wr_ack  = 1'b1;
          w_timeout = ~wr_done;
          if (r_sweep) begin
            w_bus_addr_nxt = BASE_ADDR + {4'd0, r_idx};
            w_state_nxt    = S_RD_ISSUE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rd_start    = w_rd_start;
  assign wr_start    = w_wr_start;
  assign reg_we      = w_reg_we;
  assign wr_ack      = w_wr_ack;
  assign timeout_err = w_timeout;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign reg_idx     = r_idx;
  assign reg_data    = r_reg_data;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: doc/rtc_bus_scheduler.md
Name: rtc_bus_scheduler

Overview:
- Sequences every access to the multiplexed-AD RTC bus.
- On each refresh tick, sweeps NREGS time/date registers through the read engine and loads the results into the display register file.
- Arbitrates user write requests (from the time-set UI) into the write engine between sweep reads.
- Guards both engines with a watchdog so a hung bus transaction cannot stall the design.

Parameters:
- NREGS, 7, registers read per sweep (indices 0..NREGS-1); legal range 1..16.
- BASE_ADDR, 8'h21, RTC address of index 0; address = BASE_ADDR + idx, modulo 256.
- TIMEOUT, 255, maximum cycles spent waiting for an engine done pulse; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle refresh strobe
- wr_req  in  1  write request; held high until wr_ack
- wr_addr  in  8  RTC address to write
- wr_data  in  8  data to write
- wr_ack  out  1  one-cycle pulse when a write finishes or is aborted
- rd_start  out  1  one-cycle start pulse to the read engine
- rd_done  in  1  one-cycle done pulse from the read engine
- rd_data  in  8  data captured by the read engine; valid while rd_done=1
- wr_start  out  1  one-cycle start pulse to the write engine
- wr_done  in  1  one-cycle done pulse from the write engine
- bus_addr  out  8  address presented to the active engine
- bus_wdata  out  8  write data presented to the write engine
- reg_we  out  1  register-file write strobe
- reg_idx  out  4  register-file index
- reg_data  out  8  register-file data
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset: synchronous, active-high; wins over all other inputs in the same cycle.
- Reset values: state=IDLE; idx=0; tick_pend=0; wdog=0.
- Outputs at reset: all outputs 0, including bus_addr, bus_wdata, reg_idx and reg_data.
- Reset mid-transaction: the engine is not notified. The engines share the same reset.
- State register: 6 states, registered; outputs decoded from state plus latched registers.
- IDLE
  - wr_req=1 -> latch wr_addr/wr_data into bus_addr/bus_wdata -> WR_ISSUE. A write beats a simultaneous tick; that tick sets tick_pend.
  - Otherwise, tick=1 or tick_pend=1 -> idx=0, clear tick_pend -> RD_ISSUE.
- RD_ISSUE
  - bus_addr = BASE_ADDR+idx; rd_start=1 for exactly 1 cycle; wdog=0 -> RD_WAIT.
- RD_WAIT
  - wdog increments each cycle.
  - rd_done=1 -> RD_STORE.
  - wdog reaches TIMEOUT with no rd_done -> timeout_err=1 for 1 cycle, abort the sweep with no reg_we, idx=0 -> IDLE.
  - rd_done and expiry in the same cycle: rd_done wins.
- RD_STORE
  - reg_we=1, reg_idx=idx, reg_data=rd_data as captured in the rd_done cycle; 1 cycle.
  - Then, if idx=NREGS-1 -> IDLE with idx=0.
  - Else idx+1, and if wr_req=1 -> latch the write -> WR_ISSUE; otherwise -> RD_ISSUE.
- WR_ISSUE
  - wr_start=1 for exactly 1 cycle; wdog=0 -> WR_WAIT.
- WR_WAIT
  - wr_done=1 -> wr_ack=1 for 1 cycle.
  - Watchdog expiry -> wr_ack=1 and timeout_err=1 together for 1 cycle.
  - Next state in both cases: RD_ISSUE if a sweep is in progress (idx carries the next index); otherwise IDLE.
- Sweep-in-progress flag: set on IDLE->RD_ISSUE; cleared when the sweep completes or aborts.
- tick outside IDLE sets tick_pend. Extra ticks collapse into one pending tick.
- Latency, no contention:
  - tick to first rd_start: 2 cycles.
  - A sweep with single-cycle done responses takes 3*NREGS cycles.
  - wr_req in IDLE to wr_start: 2 cycles.
- Spurious inputs: rd_done or wr_done outside the matching WAIT state is ignored. wr_req deasserted before acceptance is dropped with no ack.
- Each write is acked exactly once. wr_req still high the cycle after wr_ack is treated as a new request.
- Addresses: reg_idx is zero-extended from idx; BASE_ADDR+idx wraps at 8 bits.

Test Plan:
- Idle sweep: NREGS=7, BASE_ADDR=8'h21, read engine model answers rd_data=addr^8'hFF after 5 cycles; pulse tick.
  -> rd_start sees addresses 21..27; reg_we writes idx 0..6 with DE..D8; busy then falls; no timeout_err.
- Write during sweep: assert wr_req (addr 8'h22, data 8'h45) during the read of idx 2.
  -> after idx 2 is stored, wr_start with bus_addr=22, bus_wdata=45; wr_ack pulse; sweep resumes at idx 3 (addr 24) and finishes at idx 6.
- Simultaneous tick and wr_req in IDLE.
  -> write serviced first; wr_ack; then the full sweep starts from idx 0 with no extra idle tick needed.
- Read timeout: TIMEOUT=10; read engine never answers at idx 4.
  -> timeout_err pulses after 10 wait cycles; no reg_we for idx 4..6; IDLE; next tick restarts at addr 21.
- Write timeout: write engine silent.
  -> wr_ack and timeout_err pulse in the same cycle; busy=0 the following cycle.
- Reset mid-RD_WAIT plus tick burst: 3 ticks during a sweep, then reset asserted in the next RD_WAIT.
  -> all outputs 0 next cycle; the pending tick is discarded; no reg_we after reset.
